weight_load_ctrl: RTL and testbench
===================================

# weight_load_ctrl

Upstream write-side controller for the 3x3 convolution weight RAM bank. Accepts a 128-bit weight stream from the DMA/AXI front end and turns it into per-kernel-position write strobes, write addresses and data for the nine asymmetric weight RAMs. The RAMs are written 128 bits per beat and read 1024 bits per word. The block sits directly in front of the 3x3 weight-RAM wrapper and drives its `weight_data_One/Two/Three`, `weight_wr` and `weight_addra` inputs.

## Interface
Parameters:
- `AXI_WIDTH` = 128 — stream beat width; equals the RAM write-port width.
- `KERNEL_NUM` = 9 — kernel positions, one RAM each.
- `BEATS_PER_WORD` = 8 — write beats per 1024-bit read word (power of two).
- `WIDTH_RAM_ADDR_SIZE` = 13 — write-port address width.
- `WORD_CNT_W` = 11 — width of `word_count`; equals `WIDTH_RAM_ADDR_SIZE` − log2(`BEATS_PER_WORD`) + 1.

Ports:
- `clk` in 1 — the single clock.
- `rst_n` in 1 — reset, asynchronous and active-low.
- `start` in 1 — one-cycle pulse that begins a load; sampled only in IDLE.
- `word_count` in `WORD_CNT_W` — number of read words to load; sampled on `start`.
- `s_data` in `AXI_WIDTH` — weight beat.
- `s_valid` in 1 — beat valid.
- `s_ready` out 1 — beat accepted when `s_valid & s_ready`.
- `weight_data_One` out `AXI_WIDTH` — write data for kernel positions 0–2.
- `weight_data_Two` out `AXI_WIDTH` — write data for kernel positions 3–5.
- `weight_data_Three` out `AXI_WIDTH` — write data for kernel positions 6–8.
- `weight_wr` out `KERNEL_NUM` — one-hot write enable, bit k selects the RAM for kernel position k.
- `weight_addra` out `WIDTH_RAM_ADDR_SIZE` — write address.
- `busy` out 1 — load in progress.
- `done` out 1 — one-cycle completion pulse.

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE → LOAD on `start`, when `word_count` ≠ 0.
- IDLE → DONE on `start`, when `word_count` = 0. No writes are issued.
- LOAD → DONE when the last beat is accepted.
- DONE → IDLE unconditionally after one cycle.
- Counters: beat index b (0..7), kernel index k (0..8), word index w (0..`word_count`−1).
  - b increments on each accepted beat.
  - When b wraps, k increments.
  - When k wraps from 8 to 0, w increments.
- Stream order: for each word w, for k = 0..8, eight beats b = 0..7. Beat 0 is the least-significant 128 bits of the 1024-bit read word. Total beats = `word_count` × 72.
- Write address: `weight_addra` = {w[`WIDTH_RAM_ADDR_SIZE`−4:0], b[2:0]}.
- Write strobe and data routing:
  - `weight_wr` = one-hot(k).
  - `s_data` is registered into `weight_data_One` when k/3 = 0, `weight_data_Two` when k/3 = 1, `weight_data_Three` when k/3 = 2.
  - The two unselected data buses hold their previous value.
- Handshake:
  - `s_ready` = 1 only in LOAD. The RAM port never stalls, so there is no backpressure inside LOAD.
  - Gaps in `s_valid` freeze all counters and produce no write.
- Control pulses:
  - `start` while `busy` is ignored.
  - `word_count` is latched on `start`; later changes have no effect.
- `busy` is high in LOAD and DONE.
- `done` is high only in DONE.

## Timing
- Reset values: every output is 0; state is IDLE; all counters are 0.
- Reset asserted mid-load aborts immediately:
  - `weight_wr` is 0 on the same edge (asynchronously).
  - No `done` is generated.
  - Partial RAM contents are left as written.
- Start latency: `start` at cycle t → `s_ready` = 1 at t+1.
- Write latency: beat accepted at cycle t → `weight_wr`, `weight_addra` and the data bus are valid for exactly cycle t+1. `weight_wr` is 0 in every cycle with no preceding accept.
- Completion: last beat accepted at t → state DONE at t+1. At t+1, `done` = 1 and `s_ready` = 0, coinciding with the final write. At t+2 the block is in IDLE and `busy` = 0.
- Zero-count load: `start` with `word_count` = 0 at t → `done` at t+1, no writes.
- Address range: a maximum `word_count` of 2^(`WIDTH_RAM_ADDR_SIZE`−3) = 1024 reaches `weight_addra` = 8191 with no wrap. Larger values are out of contract; the address wraps modulo 2^13.

## Structure
- Constants belong in the shared `Para.v` defines: `AXI_WIDTH_DATA_IN`, the `WIDTH_DATA`-derived beats-per-word value, and `KERNEL_NUM`. They must not be redefined locally.
- One natural sub-module: `weight_beat_counter`, the cascaded b/k/w counter with wrap and last-beat flag. The FSM, output registers and routing stay in the top module.

## Test plan
- Single-word load: `word_count` = 1, 72 back-to-back beats with data = beat number.
  - Beat 0 → `weight_wr` = 9'h001, addr 0.
  - Beat 8 → `weight_wr` = 9'h002, addr 0.
  - Beat 71 → `weight_wr` = 9'h100, addr 7, data on `weight_data_Three`.
  - `done` is high in the same cycle as the beat-71 write.
- Multi-word with gaps: `word_count` = 3, random `s_valid` gaps.
  - Exactly 216 writes occur.
  - Word 2, k = 4, b = 5 → addr 21, `weight_wr` = 9'h010, data on `weight_data_Two`.
  - No writes occur during gaps.
- Zero count: `start` with `word_count` = 0 → `done` one cycle later, `weight_wr` never nonzero, `s_ready` stays 0.
- Start while busy: pulse `start` with `word_count` = 5 during a 2-word load → load still ends after 144 beats, with exactly one `done`.
- Reset mid-load: assert `rst_n` = 0 after 40 beats.
  - All outputs are 0 immediately; no `done`.
  - A following load with `word_count` = 1 starts at addr 0 with k = 0.
- Maximum range: `word_count` = 1024 → final write at addr 8191, `weight_wr` = 9'h100, then `done`.

Source files
------------

// File: rtl/weight_load_ctrl_pkg.sv
// Shared constants, FSM state type and kernel-to-bank mapping for the weight loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package weight_load_ctrl_pkg;

  localparam int AXI_WIDTH_DATA_IN   = 128;
  localparam int WIDTH_DATA          = 1024;
  localparam int BEATS_PER_WORD      = WIDTH_DATA / AXI_WIDTH_DATA_IN;
  localparam int KERNEL_NUM          = 9;
  localparam int WIDTH_RAM_ADDR_SIZE = 13;
  localparam int WORD_CNT_W          = WIDTH_RAM_ADDR_SIZE - $clog2(BEATS_PER_WORD) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    BANK_ONE,
    BANK_TWO,
    BANK_THREE
  } bank_t;

  // Kernel positions 0-2, 3-5 and 6-8 share one write-data bus each.
  function automatic bank_t kern_bank(input int unsigned k);
    if (k < 3)      return BANK_ONE;
    else if (k < 6) return BANK_TWO;
    else            return BANK_THREE;
  endfunction

endpackage

// File: rtl/weight_beat_counter.sv
// Cascaded beat/kernel/word counter over the weight stream, with last-beat flag.
// Latency: indices update on the edge after inc; last is combinational from the indices.
// Backpressure: none; holds while inc is low.
module weight_beat_counter
  import weight_load_ctrl_pkg::*;
#(
  parameter int KERNEL_NUM_P     = KERNEL_NUM,
  parameter int BEATS_PER_WORD_P = BEATS_PER_WORD,
  parameter int WORD_CNT_W_P     = WORD_CNT_W,
  localparam int BEAT_W = $clog2(BEATS_PER_WORD_P),
  localparam int KIDX_W = $clog2(KERNEL_NUM_P),
  localparam int WIDX_W = WORD_CNT_W_P - 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic [WORD_CNT_W_P-1:0] word_count,
  input  logic                    inc,
  output logic [BEAT_W-1:0]       beat_idx,
  output logic [KIDX_W-1:0]       kern_idx,
  output logic [WIDX_W-1:0]       word_idx,
  output logic                    last
);

  logic [WORD_CNT_W_P-1:0] word_cnt_q;

  // Restart from zero and capture the word count on clear; otherwise step b, carry into k, then w.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_idx   <= '0;
      kern_idx   <= '0;
      word_idx   <= '0;
      word_cnt_q <= '0;
    end else if (clear) begin
      beat_idx   <= '0;
      kern_idx   <= '0;
      word_idx   <= '0;
      word_cnt_q <= word_count;
    end else if (inc) begin
      if (beat_idx == BEAT_W'(BEATS_PER_WORD_P - 1)) begin
        beat_idx <= '0;
        if (kern_idx == KIDX_W'(KERNEL_NUM_P - 1)) begin
          kern_idx <= '0;
          word_idx <= word_idx + WIDX_W'(1);
        end else begin
          kern_idx <= kern_idx + KIDX_W'(1);
        end
      end else begin
        beat_idx <= beat_idx + BEAT_W'(1);
      end
    end
  end

  // Current beat is the final one of the final word of the load.
  always_comb begin
    last = (beat_idx == BEAT_W'(BEATS_PER_WORD_P - 1)) &&
           (kern_idx == KIDX_W'(KERNEL_NUM_P - 1)) &&
           ({1'b0, word_idx} == (word_cnt_q - WORD_CNT_W_P'(1)));
  end

endmodule

// File: rtl/weight_load_ctrl.sv
// Turns the 128-bit weight stream into one-hot write strobes, addresses and data for the nine weight RAMs.
// Latency: beat accepted at t is written (strobe/addr/data registered) during t+1; done coincides with the last write.
// Backpressure: s_ready is high for the whole LOAD state; the RAM side never stalls.
module weight_load_ctrl
  import weight_load_ctrl_pkg::*;
#(
  parameter int AXI_WIDTH           = AXI_WIDTH_DATA_IN,
  parameter int KERNEL_NUM_P        = KERNEL_NUM,
  parameter int BEATS_PER_WORD_P    = BEATS_PER_WORD,
  parameter int WIDTH_RAM_ADDR_SIZE_P = WIDTH_RAM_ADDR_SIZE,
  parameter int WORD_CNT_W_P        = WORD_CNT_W
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [WORD_CNT_W_P-1:0]          word_count,
  input  logic [AXI_WIDTH-1:0]             s_data,
  input  logic                             s_valid,
  output logic                             s_ready,
  output logic [AXI_WIDTH-1:0]             weight_data_One,
  output logic [AXI_WIDTH-1:0]             weight_data_Two,
  output logic [AXI_WIDTH-1:0]             weight_data_Three,
  output logic [KERNEL_NUM_P-1:0]          weight_wr,
  output logic [WIDTH_RAM_ADDR_SIZE_P-1:0] weight_addra,
  output logic                             busy,
  output logic                             done
);

  localparam int BEAT_W = $clog2(BEATS_PER_WORD_P);
  localparam int KIDX_W = $clog2(KERNEL_NUM_P);
  localparam int WIDX_W = WORD_CNT_W_P - 1;

  state_t state_q, state_d;

  logic              accept;
  logic              load_start;
  logic              last_beat;
  logic [BEAT_W-1:0] beat_idx;
  logic [KIDX_W-1:0] kern_idx;
  logic [WIDX_W-1:0] word_idx;

  assign s_ready    = (state_q == ST_LOAD);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign accept     = s_valid & s_ready;
  assign load_start = (state_q == ST_IDLE) & start;

  weight_beat_counter #(
    .KERNEL_NUM_P     (KERNEL_NUM_P),
    .BEATS_PER_WORD_P (BEATS_PER_WORD_P),
    .WORD_CNT_W_P     (WORD_CNT_W_P)
  ) u_beat_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (load_start),
    .word_count (word_count),
    .inc        (accept),
    .beat_idx   (beat_idx),
    .kern_idx   (kern_idx),
    .word_idx   (word_idx),
    .last       (last_beat)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: a zero-word load goes straight to DONE; start is ignored outside IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (word_count == '0) ? ST_DONE : ST_LOAD;
      ST_LOAD: if (accept && last_beat) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Register the accepted beat into its RAM strobe, address and bank bus; strobe drops when nothing is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_wr         <= '0;
      weight_addra      <= '0;
      weight_data_One   <= '0;
      weight_data_Two   <= '0;
      weight_data_Three <= '0;
    end else begin
      weight_wr <= '0;
      if (accept) begin
        weight_wr    <= KERNEL_NUM_P'(1) << kern_idx;
        weight_addra <= WIDTH_RAM_ADDR_SIZE_P'({word_idx, beat_idx});
        case (kern_bank(32'(kern_idx)))
          BANK_ONE: weight_data_One   <= s_data;
          BANK_TWO: weight_data_Two   <= s_data;
          default:  weight_data_Three <= s_data;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Randomized self-checking bench for weight_load_ctrl against a beat-number reference model.
// Latency: model expects each accepted beat's write one cycle later and done with the final write.
// Backpressure: model expects s_ready only while a load is in progress.
module tb_weight_load_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [10:0]  word_count;
  logic [127:0] s_data;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] weight_data_One, weight_data_Two, weight_data_Three;
  logic [8:0]   weight_wr;
  logic [12:0]  weight_addra;
  logic         busy, done;

  always #5 clk = ~clk;

  weight_load_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .word_count        (word_count),
    .s_data            (s_data),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .weight_data_One   (weight_data_One),
    .weight_data_Two   (weight_data_Two),
    .weight_data_Three (weight_data_Three),
    .weight_wr         (weight_wr),
    .weight_addra      (weight_addra),
    .busy              (busy),
    .done              (done)
  );

  int errs = 0;
  int checks = 0;

  // Reference model: phase 0 idle, 1 loading, 2 completion cycle (value for the coming cycle).
  int           phase;
  int           m_n;
  int           m_total;
  logic [8:0]   exp_wr;
  logic [12:0]  exp_addr;
  logic [127:0] bus_q [3];
  int           wr_count;
  int           done_count;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    phase  = 0;
    m_n    = 0;
    m_total = 0;
    exp_wr = '0;
    exp_addr = '0;
    for (int i = 0; i < 3; i++) bus_q[i] = '0;
  endtask

  // One clock: check outputs for this cycle, then drive inputs and predict the next cycle.
  task automatic cycle(input logic st, input logic [10:0] wc, input logic vld,
                       input logic [127:0] d, input bit en);
    int w, k, b;
    bit acc;
    @(negedge clk);
    if (weight_wr != '0) wr_count++;
    if (done) done_count++;
    if (en) begin
      chk("wr", weight_wr, exp_wr);
      chk("done", done, phase == 2);
      chk("busy", busy, phase != 0);
      chk("ready", s_ready, phase == 1);
      if (exp_wr != '0) chk("addr", weight_addra, exp_addr);
      chk("bus1", weight_data_One, bus_q[0]);
      chk("bus2", weight_data_Two, bus_q[1]);
      chk("bus3", weight_data_Three, bus_q[2]);
    end
    start      = st;
    word_count = wc;
    s_valid    = vld;
    s_data     = d;
    acc    = vld && (phase == 1);
    exp_wr = '0;
    if (acc) begin
      w = m_n / 72;
      k = (m_n % 72) / 8;
      b = m_n % 8;
      exp_wr   = 9'(1) << k;
      exp_addr = 13'((w * 8 + b) % 8192);
      bus_q[k / 3] = d;
      m_n++;
    end
    case (phase)
      0: if (st) begin
           m_n = 0;
           m_total = int'(wc) * 72;
           phase = (wc == 0) ? 2 : 1;
         end
      1: if (acc && m_n == m_total) phase = 2;
      default: phase = 0;
    endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 11'd0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    word_count = '0;
    s_valid = 1'b0;
    s_data = '0;
    model_reset();
    wr_count = 0;
    done_count = 0;

    repeat (3) @(negedge clk);
    chk("rst_wr", weight_wr, 0);
    chk("rst_addr", weight_addra, 0);
    chk("rst_d1", weight_data_One, 0);
    chk("rst_d2", weight_data_Two, 0);
    chk("rst_d3", weight_data_Three, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    idle(2);

    // Single word, back-to-back, data = beat number.
    wr_count = 0; done_count = 0;
    cycle(1'b1, 11'd1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 72; i++) cycle(1'b0, 11'd0, 1'b1, 128'(i), 1'b1);
    idle(1);
    chk("t1_last_wr", weight_wr, 9'h100);
    chk("t1_last_addr", weight_addra, 13'd7);
    chk("t1_last_data", weight_data_Three, 128'd71);
    chk("t1_last_done", done, 1);
    idle(3);
    chk("t1_writes", wr_count, 72);
    chk("t1_dones", done_count, 1);

    // Three words with random valid gaps; word_count wiggles after start.
    wr_count = 0; done_count = 0;
    cycle(1'b1, 11'd3, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3000 && phase != 0; i++)
      cycle(1'b0, 11'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)), rnd(), 1'b1);
    idle(3);
    chk("t2_writes", wr_count, 216);
    chk("t2_dones", done_count, 1);

    // Zero count with s_valid asserted: no writes, done next cycle.
    wr_count = 0; done_count = 0;
    cycle(1'b1, 11'd0, 1'b1, rnd(), 1'b1);
    cycle(1'b0, 11'd0, 1'b1, rnd(), 1'b1);
    chk("zc_done", done, 1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 11'd0, 1'b1, rnd(), 1'b1);
    chk("zc_writes", wr_count, 0);
    chk("zc_dones", done_count, 1);

    // Start pulse during a 2-word load is ignored.
    wr_count = 0; done_count = 0;
    cycle(1'b1, 11'd2, 1'b0, '0, 1'b1);
    for (int i = 0; i < 400 && phase != 0; i++)
      cycle(1'(m_n == 50), 11'd5, 1'b1, rnd(), 1'b1);
    idle(3);
    chk("sb_writes", wr_count, 144);
    chk("sb_dones", done_count, 1);

    // Reset mid-load after 40 beats.
    cycle(1'b1, 11'd2, 1'b0, '0, 1'b1);
    for (int i = 0; i < 100 && m_n < 40; i++) cycle(1'b0, 11'd0, 1'b1, rnd(), 1'b1);
    @(posedge clk);
    #2;
    start = 1'b0; s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mr_wr", weight_wr, 0);
    chk("mr_addr", weight_addra, 0);
    chk("mr_d1", weight_data_One, 0);
    chk("mr_d2", weight_data_Two, 0);
    chk("mr_d3", weight_data_Three, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_ready", s_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    wr_count = 0; done_count = 0;
    idle(3);
    chk("mr_no_done", done_count, 0);
    cycle(1'b1, 11'd1, 1'b0, '0, 1'b1);
    cycle(1'b0, 11'd0, 1'b1, rnd(), 1'b1);
    cycle(1'b0, 11'd0, 1'b0, '0, 1'b1);
    chk("mr_first_wr", weight_wr, 9'h001);
    chk("mr_first_addr", weight_addra, 0);
    for (int i = 0; i < 400 && phase != 0; i++)
      cycle(1'b0, 11'd0, 1'($urandom_range(0, 1)), rnd(), 1'b1);
    idle(2);
    chk("mr_writes", wr_count, 72);
    chk("mr_dones", done_count, 1);

    // Maximum range: 1024 words reach address 8191.
    wr_count = 0; done_count = 0;
    cycle(1'b1, 11'd1024, 1'b0, '0, 1'b1);
    for (int i = 0; i < 80000 && phase == 1; i++)
      cycle(1'b0, 11'd0, 1'b1, rnd(), m_n >= m_total - 1);
    cycle(1'b0, 11'd0, 1'b0, '0, 1'b1);
    chk("max_addr", weight_addra, 13'd8191);
    chk("max_wr", weight_wr, 9'h100);
    chk("max_done", done, 1);
    idle(2);
    chk("max_writes", wr_count, 73728);
    chk("max_dones", done_count, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
